// File: rtl/wb_bridge_pkg.sv
// Shared encodings for the Wishbone-to-native bus bridge: FSM states,
// access-size codes and region decode constants.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  localparam int CE_W = 8;

  localparam logic [3:0] REGION_FIRST = 4'h8;
  localparam logic [3:0] REGION_LAST  = 4'hC;

endpackage

// File: rtl/wb_bridge_decode.sv
// Combinational decode of a Wishbone request: region nibble to one-hot chip
// enable, byte-lane select to access size and lane offset.
module wb_bridge_decode
  import wb_bridge_pkg::*;
(
  input  logic [3:0]      region_i,
  input  logic [3:0]      sel_i,
  output logic [CE_W-1:0] ce_o,
  output logic [1:0]      hb_o,
  output logic [1:0]      off_o,
  output logic            illegal_o
);

  logic [3:0] region_idx;
  logic       region_ok;

  assign region_idx = region_i - REGION_FIRST;
  assign region_ok  = (region_i >= REGION_FIRST) && (region_i <= REGION_LAST);

  always_comb begin
    ce_o      = '0;
    hb_o      = HB_WORD;
    off_o     = 2'd0;
    illegal_o = 1'b0;

    if (region_ok) begin
      ce_o = {{(CE_W-1){1'b0}}, 1'b1} << region_idx;
    end else begin
      illegal_o = 1'b1;
    end

    case (sel_i)
      4'b0001: begin hb_o = HB_BYTE; off_o = 2'd0; end
      4'b0010: begin hb_o = HB_BYTE; off_o = 2'd1; end
      4'b0100: begin hb_o = HB_BYTE; off_o = 2'd2; end
      4'b1000: begin hb_o = HB_BYTE; off_o = 2'd3; end
      4'b0011: begin hb_o = HB_HALF; off_o = 2'd0; end
      4'b1100: begin hb_o = HB_HALF; off_o = 2'd2; end
      4'b1111: begin hb_o = HB_WORD; off_o = 2'd0; end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_bus_bridge.sv
// Wishbone slave to native request/grant bus bridge: one outstanding
// transfer, lane alignment in both directions, grant timeout and CYC abort.
module wb_bus_bridge
  import wb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [ADDR_WIDTH-1:0] i_WB_ADDR,
  input  logic [DATA_WIDTH-1:0] i_WB_DATA,
  input  logic                  i_WB_WE,
  input  logic [3:0]            i_WB_SEL,
  input  logic                  i_WB_STB,
  input  logic                  i_WB_CYC,
  output logic [DATA_WIDTH-1:0] o_WB_DATA,
  output logic                  o_WB_ACK,
  output logic                  o_WB_ERR,
  output logic [ADDR_WIDTH-1:0] o_BUS_ADDR,
  output logic [DATA_WIDTH-1:0] o_BUS_WDATA,
  output logic                  o_BUS_WE,
  output logic                  o_BUS_RE,
  output logic [1:0]            o_BUS_HB,
  output logic                  o_BUS_REQ,
  output logic [CE_W-1:0]       o_BUS_CE,
  input  logic [DATA_WIDTH-1:0] i_BUS_RDATA,
  input  logic                  i_BUS_GNT,
  output logic                  o_BUSY
);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  we_q, we_d;
  logic [1:0]            hb_q, hb_d;
  logic [1:0]            off_q, off_d;
  logic [CE_W-1:0]       ce_q, ce_d;

  logic [CE_W-1:0]       dec_ce;
  logic [1:0]            dec_hb;
  logic [1:0]            dec_off;
  logic                  dec_illegal;
  logic                  wb_req;
  logic                  unused_addr_lsb;

  assign wb_req          = i_WB_CYC & i_WB_STB;
  assign unused_addr_lsb = ^i_WB_ADDR[1:0];

  wb_bridge_decode u_decode (
    .region_i  (i_WB_ADDR[ADDR_WIDTH-1 -: 4]),
    .sel_i     (i_WB_SEL),
    .ce_o      (dec_ce),
    .hb_o      (dec_hb),
    .off_o     (dec_off),
    .illegal_o (dec_illegal)
  );

  function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] hb);
    case (hb)
      HB_BYTE: return {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
      HB_HALF: return {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
      default: return '1;
    endcase
  endfunction

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dropping CYC wins over a same-cycle grant; the grant wins over timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_req) begin
          state_d = dec_illegal ? ST_ERR : ST_REQ;
          cnt_d   = 8'd0;
        end
      end
      ST_REQ: begin
        if (!i_WB_CYC) begin
          state_d = ST_IDLE;
        end else if (i_BUS_GNT) begin
          state_d = ST_ACK;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_BUS_REQ = (state_q == ST_REQ);
    o_BUS_WE  = (state_q == ST_REQ) &&  we_q;
    o_BUS_RE  = (state_q == ST_REQ) && !we_q;
    o_BUS_CE  = (state_q == ST_REQ) ? ce_q : '0;
    o_WB_ACK  = (state_q == ST_ACK);
    o_WB_ERR  = (state_q == ST_ERR);
    o_BUSY    = (state_q != ST_IDLE);
  end

  // Native address carries the region index in its top nibble.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    hb_d    = hb_q;
    off_d   = off_q;
    ce_d    = ce_q;
    if (state_q == ST_IDLE && wb_req && !dec_illegal) begin
      addr_d  = {1'b0, i_WB_ADDR[ADDR_WIDTH-2 -: 3], i_WB_ADDR[ADDR_WIDTH-5:2], dec_off};
      wdata_d = (i_WB_DATA >> {dec_off, 3'b000}) & size_mask(dec_hb);
      we_d    = i_WB_WE;
      hb_d    = dec_hb;
      off_d   = dec_off;
      ce_d    = dec_ce;
    end
    if (state_q == ST_REQ && i_WB_CYC && i_BUS_GNT && !we_q) begin
      rdata_d = i_BUS_RDATA << {off_q, 3'b000};
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      hb_q    <= 2'b00;
      off_q   <= 2'd0;
      ce_q    <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      hb_q    <= hb_d;
      off_q   <= off_d;
      ce_q    <= ce_d;
    end
  end

  assign o_BUS_ADDR  = addr_q;
  assign o_BUS_WDATA = wdata_q;
  assign o_BUS_HB    = hb_q;
  assign o_WB_DATA   = rdata_q;

endmodule

// File: tb/tb_wb_bus_bridge.sv
// Directed bench for wb_bus_bridge: word/byte/half transfers, illegal
// requests, grant timeout, CYC abort and reset mid-transfer.
module tb_wb_bus_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_stb;
  logic        wb_cyc;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic        wb_err;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [1:0]  bus_hb;
  logic        bus_req;
  logic [7:0]  bus_ce;
  logic [31:0] bus_rdata;
  logic        bus_gnt;
  logic        busy;

  int vectors;
  int miscompares;

  wb_bus_bridge #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .TIMEOUT    (4)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_WB_ADDR   (wb_addr),
    .i_WB_DATA   (wb_wdata),
    .i_WB_WE     (wb_we),
    .i_WB_SEL    (wb_sel),
    .i_WB_STB    (wb_stb),
    .i_WB_CYC    (wb_cyc),
    .o_WB_DATA   (wb_rdata),
    .o_WB_ACK    (wb_ack),
    .o_WB_ERR    (wb_err),
    .o_BUS_ADDR  (bus_addr),
    .o_BUS_WDATA (bus_wdata),
    .o_BUS_WE    (bus_we),
    .o_BUS_RE    (bus_re),
    .o_BUS_HB    (bus_hb),
    .o_BUS_REQ   (bus_req),
    .o_BUS_CE    (bus_ce),
    .i_BUS_RDATA (bus_rdata),
    .i_BUS_GNT   (bus_gnt),
    .o_BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb_start(input logic [31:0] a, input logic [3:0] s,
                          input logic w, input logic [31:0] d);
    wb_addr  = a;
    wb_sel   = s;
    wb_we    = w;
    wb_wdata = d;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
  endtask

  task automatic wb_stop();
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    wb_addr   = '0;
    wb_wdata  = '0;
    wb_we     = 1'b0;
    wb_sel    = 4'h0;
    wb_stb    = 1'b0;
    wb_cyc    = 1'b0;
    bus_rdata = '0;
    bus_gnt   = 1'b0;
    tick();
    tick();

    chk("rst_busy", busy, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_ack", wb_ack, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wbdata", wb_rdata, 0);
    chk("rst_ce", bus_ce, 0);
    rst = 1'b0;
    tick();

    // Word read, grant in the first REQ cycle
    wb_start(32'h9000_0010, 4'hF, 1'b0, 32'h0);
    bus_gnt   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_req", bus_req, 1);
    chk("wr_re", bus_re, 1);
    chk("wr_we", bus_we, 0);
    chk("wr_ce", bus_ce, 8'h02);
    chk("wr_hb", bus_hb, 2'b10);
    chk("wr_addr", bus_addr, 32'h1000_0010);
    chk("wr_ack_early", wb_ack, 0);
    tick();
    chk("wr_ack", wb_ack, 1);
    chk("wr_data", wb_rdata, 32'hDEAD_BEEF);
    chk("wr_req_off", bus_req, 0);
    wb_stop();
    bus_gnt = 1'b0;
    tick();
    chk("wr_ack_one", wb_ack, 0);
    chk("wr_idle", busy, 0);

    // Byte write to lane 3
    wb_start(32'hA000_0003, 4'b1000, 1'b1, 32'h5A00_0000);
    tick();
    chk("bw_addr", bus_addr, 32'h2000_0003);
    chk("bw_wdata", bus_wdata, 32'h0000_005A);
    chk("bw_we", bus_we, 1);
    chk("bw_re", bus_re, 0);
    chk("bw_hb", bus_hb, 2'b00);
    chk("bw_ce", bus_ce, 8'h04);
    bus_gnt = 1'b1;
    tick();
    chk("bw_ack", wb_ack, 1);
    chk("bw_data_held", wb_rdata, 32'hDEAD_BEEF);
    wb_stop();
    bus_gnt = 1'b0;
    tick();
    chk("bw_ack_one", wb_ack, 0);

    // Upper half write and upper half read
    wb_start(32'h8000_0004, 4'b1100, 1'b1, 32'h1234_0000);
    tick();
    chk("hw_wdata", bus_wdata, 32'h0000_1234);
    chk("hw_hb", bus_hb, 2'b01);
    chk("hw_addr", bus_addr, 32'h0000_0006);
    chk("hw_ce", bus_ce, 8'h01);
    bus_gnt = 1'b1;
    tick();
    chk("hw_ack", wb_ack, 1);
    wb_stop();
    bus_gnt = 1'b0;
    tick();
    wb_start(32'h8000_0004, 4'b1100, 1'b0, 32'h0);
    bus_rdata = 32'h0000_BEEF;
    tick();
    chk("hr_re", bus_re, 1);
    bus_gnt = 1'b1;
    tick();
    chk("hr_ack", wb_ack, 1);
    chk("hr_data", wb_rdata, 32'hBEEF_0000);
    wb_stop();
    bus_gnt = 1'b0;
    tick();

    // Illegal SEL pattern
    wb_start(32'h8000_0000, 4'b0110, 1'b0, 32'h0);
    tick();
    chk("isel_err", wb_err, 1);
    chk("isel_req", bus_req, 0);
    chk("isel_ack", wb_ack, 0);
    wb_stop();
    tick();
    chk("isel_err_one", wb_err, 0);
    chk("isel_req2", bus_req, 0);

    // Illegal region
    wb_start(32'h1000_0000, 4'hF, 1'b0, 32'h0);
    tick();
    chk("ireg_err", wb_err, 1);
    chk("ireg_req", bus_req, 0);
    wb_stop();
    tick();
    chk("ireg_err_one", wb_err, 0);

    // Grant timeout with TIMEOUT = 4
    wb_start(32'hC000_0000, 4'hF, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_req", bus_req, 1);
      chk("to_ce", bus_ce, 8'h10);
      chk("to_err_early", wb_err, 0);
    end
    tick();
    chk("to_err", wb_err, 1);
    chk("to_req_off", bus_req, 0);
    chk("to_ce_off", bus_ce, 0);
    chk("to_ack", wb_ack, 0);
    wb_stop();
    tick();
    chk("to_err_one", wb_err, 0);
    chk("to_idle", busy, 0);

    // CYC dropped in the second REQ cycle while GNT pulses
    wb_start(32'hB000_0000, 4'hF, 1'b0, 32'h0);
    bus_rdata = 32'h0BAD_F00D;
    tick();
    chk("ab_req1", bus_req, 1);
    tick();
    chk("ab_req2", bus_req, 1);
    wb_stop();
    bus_gnt = 1'b1;
    tick();
    chk("ab_req_off", bus_req, 0);
    chk("ab_ack", wb_ack, 0);
    chk("ab_err", wb_err, 0);
    chk("ab_idle", busy, 0);
    bus_gnt = 1'b0;
    tick();
    chk("ab_ack2", wb_ack, 0);
    chk("ab_err2", wb_err, 0);
    chk("ab_data", wb_rdata, 32'hBEEF_0000);

    // Reset in the first REQ cycle, then back-to-back word reads
    wb_start(32'h9000_0020, 4'hF, 1'b0, 32'h0);
    tick();
    chk("rr_req", bus_req, 1);
    rst = 1'b1;
    tick();
    chk("rr_req_off", bus_req, 0);
    chk("rr_ack", wb_ack, 0);
    chk("rr_err", wb_err, 0);
    chk("rr_busy", busy, 0);
    chk("rr_addr", bus_addr, 0);
    chk("rr_wdata", bus_wdata, 0);
    chk("rr_hb", bus_hb, 0);
    chk("rr_ce", bus_ce, 0);
    chk("rr_wbdata", wb_rdata, 0);
    rst = 1'b0;
    wb_start(32'h8000_0000, 4'hF, 1'b0, 32'h0);
    bus_gnt   = 1'b1;
    bus_rdata = 32'h1111_1111;
    tick();
    chk("b2b_req1", bus_req, 1);
    tick();
    chk("b2b_ack1", wb_ack, 1);
    chk("b2b_data1", wb_rdata, 32'h1111_1111);
    wb_addr   = 32'h8000_0008;
    bus_rdata = 32'h2222_2222;
    tick();
    chk("b2b_gap", wb_ack, 0);
    chk("b2b_gap_idle", busy, 0);
    tick();
    chk("b2b_req2", bus_req, 1);
    chk("b2b_addr2", bus_addr, 32'h0000_0008);
    tick();
    chk("b2b_ack2", wb_ack, 1);
    chk("b2b_data2", wb_rdata, 32'h2222_2222);
    wb_stop();
    bus_gnt = 1'b0;
    tick();
    chk("b2b_end", wb_ack, 0);
    chk("b2b_hold", wb_rdata, 32'h2222_2222);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
